// File: rtl/mul_pkg.sv
// Shared types and sizing for the iterative shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_WIDTH = 32;
    localparam int CNT_W     = $clog2(MUL_WIDTH);

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/iter_mul_if.sv
// Operand/result bundle between the deserialiser, the multiplier and the serialiser.
interface iter_mul_if
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] z;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, a, b,
        input  z, busy, done, overflow
    );

    modport slave (
        input  start, a, b,
        output z, busy, done, overflow
    );
endinterface

// File: rtl/iter_mul.sv
// Radix-2 shift-add unsigned multiplier, one partial product per cycle; done WIDTH+1 edges after launch.
// No backpressure: start rising edges outside IDLE are dropped; ITER_MUL_SAT_EN saturates z on overflow.
module iter_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    iter_mul_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    mul_state_t         state_q, state_d;
    logic               start_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic               ovf_q, ovf_d;

    logic               launch;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier_step;
    logic               prod_hi_nz;

    assign launch = bus.start & ~start_q & (state_q == IDLE);

    // One step of {sum, acc_lo, mplier} >> 1; after WIDTH steps acc holds the full product.
    always_comb begin
        sum         = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
        acc_step    = {sum, acc_q[WIDTH-1:1]};
        mplier_step = {acc_q[0], mplier_q[WIDTH-1:1]};
        prod_hi_nz  = |acc_step[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch)          state_d = CALC;
            CALC:    if (cnt_q == '0)     state_d = DONE;
            DONE:    if (!bus.start)      state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        z_d      = z_q;
        ovf_d    = ovf_q;
        if (launch) begin
            mcand_d  = bus.a;
            mplier_d = bus.b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH - 1);
        end else if (state_q == CALC) begin
            acc_d    = acc_step;
            mplier_d = mplier_step;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                ovf_d = prod_hi_nz;
`ifdef ITER_MUL_SAT_EN
                z_d   = prod_hi_nz ? {WIDTH{1'b1}} : acc_step[WIDTH-1:0];
`else
                z_d   = acc_step[WIDTH-1:0];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            z_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            start_q  <= bus.start;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.z        = z_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q == CALC);
    assign bus.done     = (state_q == DONE);

endmodule
